// File: rtl/quad_pkg.sv
// Shared types for the quadrature decoder: FSM states, step classification
// and the mapping from synchronized channel levels to Gray-code positions.
package quad_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        INIT,
        S00,
        S01,
        S11,
        S10
    } quad_state_t;

    typedef enum logic [1:0] {
        MV_NONE,
        MV_UP,
        MV_DOWN,
        MV_ERR
    } quad_move_t;

    function automatic quad_state_t ab_to_state(input logic [1:0] ab);
        case (ab)
            2'b00:   return S00;
            2'b01:   return S01;
            2'b11:   return S11;
            default: return S10;
        endcase
    endfunction

    // Position along the up sequence S00->S01->S11->S10, so a step is a +/-1 difference mod 4.
    function automatic logic [1:0] state_pos(input quad_state_t s);
        case (s)
            S01:     return 2'd1;
            S11:     return 2'd2;
            S10:     return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder inputs, control and decoded outputs of quad_decoder bundled as one port.
interface quad_decoder_if
    import quad_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             a_in;
    logic             b_in;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] d_in;
    logic             clr_err;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             err_flag;

    modport master (
        output a_in, b_in, enable, load, d_in, clr_err,
        input  count, dir, step, err_flag
    );

    modport slave (
        input  a_in, b_in, enable, load, d_in, clr_err,
        output count, dir, step, err_flag
    );
endinterface

// File: rtl/quad_decoder_sync2.sv
// One-bit two-flop synchronizer for an asynchronous quadrature channel.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments let both flops sample the same edge, forming a true two-stage chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes A/B, tracks the Gray-code state and keeps a
// modulo-2^WIDTH position count with direction, step pulse and sticky error flag.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    quad_decoder_if.slave  bus
);
    logic             a_s;
    logic             b_s;
    logic [1:0]       primed_q;
    quad_state_t      state_q;
    quad_state_t      ab_state_d;
    quad_move_t       move_d;
    logic             step_valid_d;
    logic [1:0]       delta_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_step_d;
    logic             dir_q;
    logic             step_q;
    logic             err_q;

    sync2 u_sync_a (.clk(clk), .rst(rst), .d_i(bus.a_in), .q_o(a_s));
    sync2 u_sync_b (.clk(clk), .rst(rst), .d_i(bus.b_in), .q_o(b_s));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ab_state_d   = ab_to_state({a_s, b_s});
        delta_d      = state_pos(ab_state_d) - state_pos(state_q);
        move_d       = MV_NONE;
        if (state_q != INIT) begin
            case (delta_d)
                2'd1:    move_d = MV_UP;
                2'd3:    move_d = MV_DOWN;
                2'd2:    move_d = MV_ERR;
                default: move_d = MV_NONE;
            endcase
        end
        step_valid_d = (move_d == MV_UP) || (move_d == MV_DOWN);
        count_step_d = (move_d == MV_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            primed_q <= 2'b00;
            state_q  <= INIT;
            count_q  <= '0;
            dir_q    <= 1'b1;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            primed_q <= {primed_q[0], 1'b1};
            step_q   <= 1'b0;
            // INIT waits until both synchronizer stages hold post-reset samples of the real lines.
            if (state_q != INIT || primed_q[1]) begin
                state_q <= ab_state_d;
            end
            if (bus.enable && step_valid_d) begin
                dir_q <= (move_d == MV_UP);
                if (!bus.load) begin
                    count_q <= count_step_d;
                    step_q  <= 1'b1;
                end
            end
            if (bus.load) begin
                count_q <= bus.d_in;
            end
            if (move_d == MV_ERR) begin
                err_q <= 1'b1;
            end else if (bus.clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.count    = count_q;
    assign bus.dir      = dir_q;
    assign bus.step     = step_q;
    assign bus.err_flag = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: expected outputs are queued when an input
// change is driven and popped at the cycle the decoder must present them.
module tb_quad_decoder;
    import quad_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quad_decoder_if #(.WIDTH(W)) bus ();
    quad_decoder #(.WIDTH(W)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string          tag;
        logic [W-1:0]   count;
        logic           dir;
        logic           step;
        logic           err;
    } exp_t;

    exp_t         sb_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] m_count;
    logic         m_dir;
    logic         m_err;
    logic         m_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check($sformatf("%s.count", e.tag), 32'(bus.count), 32'(e.count));
        check($sformatf("%s.dir", e.tag), 32'(bus.dir), 32'(e.dir));
        check($sformatf("%s.step", e.tag), 32'(bus.step), 32'(e.step));
        check($sformatf("%s.err", e.tag), 32'(bus.err_flag), 32'(e.err));
    endtask

    // kind: 1 = up step, -1 = down step, 0 = no change, 2 = illegal two-bit jump.
    // ld / clr are asserted on the edge where the decoder acts on the change.
    task automatic apply(input string tag, input logic [1:0] ab, input int kind,
                         input logic ld = 1'b0, input logic [W-1:0] ld_val = '0,
                         input logic clr = 1'b0);
        exp_t         e;
        logic         valid;
        logic [W-1:0] prev_count;
        prev_count = m_count;
        valid      = (kind == 1) || (kind == -1);
        @(negedge clk);
        {bus.a_in, bus.b_in} = ab;
        if (m_en && valid) m_dir = (kind == 1);
        if (ld) m_count = ld_val;
        else if (m_en && valid) m_count = (kind == 1) ? m_count + W'(1) : m_count - W'(1);
        if (kind == 2) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        e.tag   = tag;
        e.count = m_count;
        e.dir   = m_dir;
        e.step  = m_en && valid && !ld;
        e.err   = m_err;
        sb_q.push_back(e);
        repeat (2) @(negedge clk);
        check($sformatf("%s.early_count", tag), 32'(bus.count), 32'(prev_count));
        check($sformatf("%s.early_step", tag), 32'(bus.step), 32'(0));
        bus.load    = ld;
        bus.d_in    = ld_val;
        bus.clr_err = clr;
        @(negedge clk);
        bus.load    = 1'b0;
        bus.clr_err = 1'b0;
        e = sb_q.pop_front();
        check_outputs(e);
        @(negedge clk);
        check($sformatf("%s.pulse_end", tag), 32'(bus.step), 32'(0));
    endtask

    task automatic do_load(input string tag, input logic [W-1:0] val);
        @(negedge clk);
        bus.load = 1'b1;
        bus.d_in = val;
        @(negedge clk);
        bus.load = 1'b0;
        m_count  = val;
        check($sformatf("%s.count", tag), 32'(bus.count), 32'(m_count));
        check($sformatf("%s.step", tag), 32'(bus.step), 32'(0));
        check($sformatf("%s.dir", tag), 32'(bus.dir), 32'(m_dir));
    endtask

    task automatic do_clr(input string tag);
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        m_err       = 1'b0;
        check($sformatf("%s.err", tag), 32'(bus.err_flag), 32'(m_err));
    endtask

    task automatic check_reset_state(input string tag);
        check($sformatf("%s.count", tag), 32'(bus.count), 32'(0));
        check($sformatf("%s.dir", tag), 32'(bus.dir), 32'(1));
        check($sformatf("%s.step", tag), 32'(bus.step), 32'(0));
        check($sformatf("%s.err", tag), 32'(bus.err_flag), 32'(0));
    endtask

    initial begin
        rst         = 1'b1;
        bus.a_in    = 1'b1;
        bus.b_in    = 1'b1;
        bus.enable  = 1'b1;
        bus.load    = 1'b0;
        bus.d_in    = '0;
        bus.clr_err = 1'b0;
        m_count     = '0;
        m_dir       = 1'b1;
        m_err       = 1'b0;
        m_en        = 1'b1;

        // Scenario 1: reset with lines at 11; INIT must settle on S11 quietly.
        repeat (2) @(negedge clk);
        check_reset_state("s1_reset");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_reset_state("s1_init");
        // 11->10 is only an up step if INIT resolved to S11.
        apply("s1_first_up", 2'b10, 1);
        apply("s2_to_00", 2'b00, 1);

        // Scenario 2: load 5, four up steps.
        do_load("s2_load", 4'h5);
        apply("s2_up1", 2'b01, 1);
        apply("s2_up2", 2'b11, 1);
        apply("s2_up3", 2'b10, 1);
        apply("s2_up4", 2'b00, 1);
        check("s2_final", 32'(bus.count), 32'h9);

        // Scenario 3: down through zero, then up through all-ones.
        do_load("s3_load1", 4'h1);
        apply("s3_dn1", 2'b10, -1);
        apply("s3_dn2", 2'b11, -1);
        apply("s3_dn3", 2'b01, -1);
        check("s3_wrap_down", 32'(bus.count), 32'hE);
        check("s3_dir_down", 32'(bus.dir), 32'h0);
        do_load("s3_loadF", 4'hF);
        apply("s3_up_wrap", 2'b11, 1);
        check("s3_wrap_up", 32'(bus.count), 32'h0);

        // Scenario 4: disabled steps are tracked but not counted.
        bus.enable = 1'b0;
        m_en       = 1'b0;
        apply("s4_dis1", 2'b10, 1);
        apply("s4_dis2", 2'b00, 1);
        bus.enable = 1'b1;
        m_en       = 1'b1;
        apply("s4_en_up", 2'b01, 1);
        check("s4_final", 32'(bus.count), 32'h1);

        // Scenario 5: sticky error, set beats clear.
        apply("s5_dn", 2'b00, -1);
        apply("s5_illegal", 2'b11, 2);
        apply("s5_illegal_clr", 2'b00, 2, 1'b0, '0, 1'b1);
        do_clr("s5_clr");

        // Scenario 6: load during a step, then reset mid-sequence.
        apply("s6_load_step", 2'b01, 1, 1'b1, 4'hA);
        check("s6_load_val", 32'(bus.count), 32'hA);
        apply("s6_up", 2'b11, 1);
        @(negedge clk);
        {bus.a_in, bus.b_in} = 2'b10;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("s6_reset");
        m_count = '0;
        m_dir   = 1'b1;
        m_err   = 1'b0;
        rst     = 1'b0;
        repeat (6) @(negedge clk);
        check_reset_state("s6_init");
        apply("s6_after_init", 2'b00, 1);
        check("s6_final", 32'(bus.count), 32'h1);

        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
